// File: rtl/asr_seq8.sv
// asr_seq8: multi-cycle arithmetic shift-right sequencer built around the ASR8 stage (0..3 per pass).
// Optional macro ASR_SEQ_LSR_EN adds a 'logical' input that selects a zero-filling shift.
module asr_seq8 #(
   parameter int SHW = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic [7:0]     d_in,
   input  logic [SHW-1:0] shamt_total,
`ifdef ASR_SEQ_LSR_EN
   input  logic           logical,
`endif
   output logic [7:0]     d_out,
   output logic           busy,
   output logic           done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state_r, state_s;
   logic [7:0]     data_r, data_s;
   logic [SHW-1:0] rem_r, rem_s;
   logic           logical_r, logical_s;
   logic           logical_in_s;
   logic [1:0]     step_s;
   logic [SHW-1:0] rem_left_s;
   logic [7:0]     pass_s;
   logic [7:0]     d_out_r;
   logic           busy_r, busy_s;
   logic           done_r, done_s;
   logic           load_out_s;

   // ASR8 stage: sign bit replicated into the vacated MSBs
   function automatic logic [7:0] asr8(input logic [7:0] d, input logic [1:0] sh);
      logic [7:0] r;
      case (sh)
         2'd0:    r = d;
         2'd1:    r = {d[7], d[7:1]};
         2'd2:    r = {{2{d[7]}}, d[7:2]};
         2'd3:    r = {{3{d[7]}}, d[7:3]};
         default: r = d;
      endcase
      return r;
   endfunction

`ifdef ASR_SEQ_LSR_EN
   assign logical_in_s = logical;
`else
   assign logical_in_s = 1'b0;
`endif

   // Per-pass datapath: step never exceeds rem, so rem cannot underflow
   always_comb begin
      step_s = 2'd0;
      if (rem_r >= SHW'(3)) begin
         step_s = 2'd3;
      end else begin
         step_s = rem_r[1:0];
      end
      rem_left_s = rem_r - SHW'(step_s);
      if (logical_r) begin
         pass_s = data_r >> step_s;
      end else begin
         pass_s = asr8(data_r, step_s);
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         data_r    <= 8'h00;
         rem_r     <= '0;
         logical_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         data_r    <= data_s;
         rem_r     <= rem_s;
         logical_r <= logical_s;
      end
   end

   // Next-state logic: a start in DONE is accepted exactly like one in IDLE
   always_comb begin
      state_s   = state_r;
      data_s    = data_r;
      rem_s     = rem_r;
      logical_s = logical_r;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               data_s    = d_in;
               rem_s     = shamt_total;
               logical_s = logical_in_s;
               if (shamt_total == '0) begin
                  state_s = DONE;
               end else begin
                  state_s = SHIFT;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            data_s = pass_s;
            rem_s  = rem_left_s;
            if (rem_left_s == '0) begin
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output decode from the next state so busy/done/d_out can be registered
   always_comb begin
      busy_s     = (state_s == SHIFT);
      done_s     = (state_s == DONE);
      load_out_s = (state_s == DONE);
   end

   // Registered outputs; d_out only changes on entry to DONE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d_out_r <= 8'h00;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         busy_r <= busy_s;
         done_r <= done_s;
         if (load_out_s) begin
            d_out_r <= data_s;
         end else begin
            d_out_r <= d_out_r;
         end
      end
   end

   assign d_out = d_out_r;
   assign busy  = busy_r;
   assign done  = done_r;

endmodule

// File: tb/tb_asr_seq8.sv
// Scoreboard bench for asr_seq8: directed operands, expected result and done cycle queued per start.
module tb_asr_seq8;

   localparam int SHW = 4;

   logic           clk;
   logic           reset_n;
   logic           start;
   logic [7:0]     d_in;
   logic [SHW-1:0] shamt_total;
`ifdef ASR_SEQ_LSR_EN
   logic           logical;
`endif
   logic [7:0]     d_out;
   logic           busy;
   logic           done;

   typedef struct {
      logic [7:0] val;
      int         cyc;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   cyc;
   int   checks;
   int   errors;

   asr_seq8 #(.SHW(SHW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .d_in        (d_in),
      .shamt_total (shamt_total),
`ifdef ASR_SEQ_LSR_EN
      .logical     (logical),
`endif
      .d_out       (d_out),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every done pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (busy && done) begin
         checks++;
         errors++;
         $display("FAIL busy_done_overlap at cycle %0d", cyc);
      end
      if (done) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done at cycle %0d d_out=%h", cyc, d_out);
         end else begin
            e = q.pop_front();
            if (d_out !== e.val || cyc != e.cyc) begin
               errors++;
               $display("FAIL result: got d_out=%h at cycle %0d, expected %h at cycle %0d",
                        d_out, cyc, e.val, e.cyc);
            end
         end
      end
   end

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Called at a falling edge; queues the result expected ceil(n/3)+1 cycles after acceptance
   task automatic issue(input logic [7:0] d, input logic [SHW-1:0] n, input logic [7:0] exp);
      exp_t x;
      start       = 1'b1;
      d_in        = d;
      shamt_total = n;
      x.val = exp;
      x.cyc = cyc + (int'(n) + 2) / 3 + 1;
      q.push_back(x);
      @(posedge clk);
      @(negedge clk);
      check("busy_after_accept", {7'd0, busy}, {7'd0, (n != '0)});
      start = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 60) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d results still pending, expected 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      cyc         = 0;
      checks      = 0;
      errors      = 0;
      reset_n     = 1'b0;
      start       = 1'b0;
      d_in        = 8'h00;
      shamt_total = '0;
`ifdef ASR_SEQ_LSR_EN
      logical     = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("reset_d_out", d_out, 8'h00);
      check("reset_busy", {7'd0, busy}, 8'h00);
      check("reset_done", {7'd0, done}, 8'h00);
      reset_n = 1'b1;
      @(negedge clk);

      issue(8'b0101_1001, 4'd0, 8'b0101_1001);
      drain();
      issue(8'b1011_1011, 4'd2, 8'b1110_1110);
      drain();
      issue(8'b1011_1011, 4'd7, 8'b1111_1111);
      drain();

      // Reset one cycle into a 7-bit shift: operation abandoned, no done pulse
      start       = 1'b1;
      d_in        = 8'hBB;
      shamt_total = 4'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midshift_reset_d_out", d_out, 8'h00);
      check("midshift_reset_busy", {7'd0, busy}, 8'h00);
      check("midshift_reset_done", {7'd0, done}, 8'h00);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);

      // start during SHIFT ignored, then a start accepted in the DONE cycle
      issue(8'b0101_1001, 4'd5, 8'b0000_0010);
      start       = 1'b1;
      d_in        = 8'hFF;
      shamt_total = 4'd1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("done_cycle_before_restart", {7'd0, done}, 8'h01);
      issue(8'b0000_0010, 4'd1, 8'b0000_0001);
      drain();

      issue(8'h80, 4'd15, 8'hFF);
      drain();
      issue(8'h7F, 4'd15, 8'h00);
      drain();
      issue(8'hC4, 4'd3, 8'hF8);
      drain();

`ifdef ASR_SEQ_LSR_EN
      logical = 1'b1;
      issue(8'b1011_1011, 4'd4, 8'b0000_1011);
      drain();
      logical = 1'b0;
      issue(8'b1011_1011, 4'd4, 8'b1111_1011);
      drain();
`endif

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/asr_seq8.md
Name: asr_seq8

Overview:
Multi-cycle arithmetic shift-right sequencer that drives the existing ASR8 combinational stage (8-bit data, 2-bit shamt, 0–3 per pass). It accepts an 8-bit operand and a total shift amount wider than ASR8 supports. It then iterates ASR8 passes over a holding register until the full amount is applied, and presents the result with a done pulse. It sits directly upstream of ASR8: it feeds ASR8's d_in and shamt and consumes d_out back each cycle.

Parameters:
SHW, 4, width of shamt_total; total shift 0..2^SHW-1.

Ports:
clk  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled on rising clk edge.
d_in  input  8  operand, captured when start is accepted.
shamt_total  input  SHW  total right-shift amount, captured with d_in.
d_out  output  8  result register; holds the last result until the next accepted start.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse when d_out becomes valid.

Interface decided: one clock (clk); reset is asynchronous and active-low (reset_n).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE.
  - d_out=8'h00, busy=0, done=0.
  - Internal data register and remaining count are cleared.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE, start=1:
  - Load data_reg=d_in and rem=shamt_total.
  - Next state: DONE if shamt_total==0, else SHIFT.
- SHIFT, each cycle:
  - step=min(rem,3), driven to ASR8 shamt; data_reg drives ASR8 d_in.
  - On the edge: data_reg<=ASR8 d_out, rem<=rem-step.
  - If rem-step==0, next state is DONE.
- DONE:
  - done=1 for exactly one cycle; d_out<=data_reg on entry, so it is valid in the same cycle done is high.
  - Next state is IDLE.
  - start=1 during DONE is accepted, same as in IDLE: loads new operands, done still pulses this cycle.
- start while busy (SHIFT) is ignored; captured operands are unaffected.
- Latency: done is high ceil(n/3)+1 cycles after the accepting edge (n=0 → 1, n=3 → 2, n=7 → 4, n=15 → 6).
- Arithmetic: sign bit d_in[7] replicated on every pass. Shifts ≥7 give 8'hFF for negative operands and 8'h00 for non-negative operands; no special case is needed.
- rem never underflows, because step ≤ rem by construction.
- Reset asserted mid-SHIFT abandons the operation: no done pulse, and d_out returns to 8'h00.
- busy and done are never high together.

Optional Feature:
Macro ASR_SEQ_LSR_EN.
- Defined: adds input port `logical` (1 bit), captured with start. When 1, each pass zero-fills: vacated MSBs are 0, implemented as a logical right shift of data_reg instead of the ASR8 path. When 0, behaviour is arithmetic as above.
- Undefined: port absent; always arithmetic.

Test Plan:
1. Reset with reset_n=0 asserted mid-SHIFT (d_in=8'hBB, shamt=7, after 1 cycle) → immediate d_out=8'h00, busy=0, done=0; no done pulse after release; state IDLE.
2. start, d_in=8'b0101_1001, shamt_total=0 → done 1 cycle later, d_out=8'b0101_1001, busy never high.
3. start, d_in=8'b1011_1011, shamt_total=2 → single pass; done 2 cycles later, d_out=8'b1110_1110.
4. start, d_in=8'b1011_1011, shamt_total=7 → passes 3,3,1 (ASR8 shamt sequence 3,3,1); done 4 cycles later, d_out=8'b1111_1111.
5. start, d_in=8'b0101_1001, shamt_total=5; start re-pulsed with d_in=8'hFF during SHIFT → ignored; done 3 cycles after first start, d_out=8'b0000_0010. start in the DONE cycle with shamt_total=1 → next done shows 8'b0000_0001.
6. (ASR_SEQ_LSR_EN) logical=1, d_in=8'b1011_1011, shamt_total=4 → d_out=8'b0000_1011. Same operands with logical=0 → d_out=8'b1111_1011.
